core_bus_interface: RTL and testbench

Parametrised memory-port adapter for the next-generation multi-cycle core. It replaces the core's fixed-latency read/write memory ports with a registered valid/ready bus, so the core can run against wait-stated memories. It stalls the core while a transfer is in flight. It serialises a simultaneous store and load, and converts bus errors and unresponsive slaves into a sticky fault that feeds the core's trap logic.

---
 rtl/core_bus_interface.sv | 190 +++++++++++++++++++
 tb/tb_core_bus_interface.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_interface.sv
// ---------------------------------------------------------------------------
// core_bus_interface
//
// Adapts the core's request-and-hold load/store ports to a registered
// valid/ready bus. The core is stalled while a transfer is in flight. A store
// and a load requested together are issued in that order. A bus error, or a
// slave that never answers, parks the block in a sticky FAULT state that only
// reset clears.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   core_read_request     : load request, held until core_done
//   core_read_address     : load address
//   core_write_request    : store request, held until core_done
//   core_write_address    : store address
//   core_write_data       : store data
//   core_write_mask       : bit-granular store mask
//   core_read_data        : registered load result, valid with core_done
//   core_done             : one-cycle completion pulse
//   stall                 : core must hold its state
//   fault                 : sticky bus-error / timeout flag
//   bus_valid/bus_write   : request valid / 1 = store
//   bus_address           : request address
//   bus_write_data/mask   : store data and mask
//   bus_ready             : slave completes the request this cycle
//   bus_read_data         : load data, sampled on handshake
//   bus_error             : slave error, sampled on handshake
// ---------------------------------------------------------------------------
module core_bus_interface #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_read_request,
    input  logic [ADDR_WIDTH-1:0] core_read_address,
    input  logic                  core_write_request,
    input  logic [ADDR_WIDTH-1:0] core_write_address,
    input  logic [DATA_WIDTH-1:0] core_write_data,
    input  logic [DATA_WIDTH-1:0] core_write_mask,
    output logic [DATA_WIDTH-1:0] core_read_data,
    output logic                  core_done,
    output logic                  stall,
    output logic                  fault,
    output logic                  bus_valid,
    output logic                  bus_write,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_write_data,
    output logic [DATA_WIDTH-1:0] bus_write_mask,
    input  logic                  bus_ready,
    input  logic [DATA_WIDTH-1:0] bus_read_data,
    input  logic                  bus_error
);

    // A zero timeout still needs a legal (1-bit) counter; it is simply unused.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESPOND,
        S_FAULT
    } state_t;

    state_t                r_state;
    logic                  r_pending_read;
    logic [ADDR_WIDTH-1:0] r_read_address;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_core_read_data;
    logic                  r_core_done;
    logic                  r_stall;
    logic                  r_fault;
    logic                  r_bus_valid;
    logic                  r_bus_write;
    logic [ADDR_WIDTH-1:0] r_bus_address;
    logic [DATA_WIDTH-1:0] r_bus_write_data;
    logic [DATA_WIDTH-1:0] r_bus_write_mask;

    logic                  w_handshake;
    logic [CNT_W:0]        w_count_inc;
    logic                  w_timeout;

    assign w_handshake = r_bus_valid & bus_ready;
    // Counter value after this waiting cycle; the fault is taken on the edge
    // that would complete the TIMEOUT_CYCLES-th wait, so bus_valid is high
    // for exactly TIMEOUT_CYCLES cycles against a dead slave.
    assign w_count_inc = {1'b0, r_count} + (CNT_W + 1)'(1);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (w_count_inc >= TO_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_pending_read   <= 1'b0;
            r_read_address   <= '0;
            r_count          <= '0;
            r_core_read_data <= '0;
            r_core_done      <= 1'b0;
            r_stall          <= 1'b0;
            r_fault          <= 1'b0;
            r_bus_valid      <= 1'b0;
            r_bus_write      <= 1'b0;
            r_bus_address    <= '0;
            r_bus_write_data <= '0;
            r_bus_write_mask <= '0;
        end else begin
            r_core_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_count <= '0;
                    if (core_write_request) begin
                        // Store goes first; a simultaneous load is remembered.
                        r_state          <= S_WRITE;
                        r_bus_valid      <= 1'b1;
                        r_bus_write      <= 1'b1;
                        r_bus_address    <= core_write_address;
                        r_bus_write_data <= core_write_data;
                        r_bus_write_mask <= core_write_mask;
                        r_pending_read   <= core_read_request;
                        r_read_address   <= core_read_address;
                        r_stall          <= 1'b1;
                    end else if (core_read_request) begin
                        r_state       <= S_READ;
                        r_bus_valid   <= 1'b1;
                        r_bus_write   <= 1'b0;
                        r_bus_address <= core_read_address;
                        r_stall       <= 1'b1;
                    end else begin
                        r_stall <= 1'b0;
                    end
                end
                S_WRITE, S_READ: begin
                    if (w_handshake) begin
                        if (bus_error) begin
                            r_state     <= S_FAULT;
                            r_bus_valid <= 1'b0;
                            r_fault     <= 1'b1;
                        end else if (r_state == S_WRITE && r_pending_read) begin
                            // Chain straight into the load without dropping valid.
                            r_state        <= S_READ;
                            r_pending_read <= 1'b0;
                            r_bus_write    <= 1'b0;
                            r_bus_address  <= r_read_address;
                            r_count        <= '0;
                        end else begin
                            if (r_state == S_READ) begin
                                r_core_read_data <= bus_read_data;
                            end
                            r_state     <= S_RESPOND;
                            r_bus_valid <= 1'b0;
                            r_stall     <= 1'b0;
                            r_core_done <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= S_FAULT;
                        r_bus_valid <= 1'b0;
                        r_fault     <= 1'b1;
                    end else if (r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_RESPOND: begin
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    r_state     <= S_FAULT;
                    r_bus_valid <= 1'b0;
                    r_stall     <= 1'b1;
                    r_fault     <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_read_data = r_core_read_data;
    assign core_done      = r_core_done;
    assign stall          = r_stall;
    assign fault          = r_fault;
    assign bus_valid      = r_bus_valid;
    assign bus_write      = r_bus_write;
    assign bus_address    = r_bus_address;
    assign bus_write_data = r_bus_write_data;
    assign bus_write_mask = r_bus_write_mask;

endmodule

// File: tb/tb_core_bus_interface.sv
// ---------------------------------------------------------------------------
// tb_core_bus_interface
//
// Directed and randomised transfers against core_bus_interface. The bench plays
// the bus slave (a sparse memory with configurable wait states), keeps a queue
// of the bus transfers each core request should produce, and compares outputs
// every cycle. A second instance with the timeout disabled is exercised last.
// ---------------------------------------------------------------------------
module tb_core_bus_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req, wr_req;
    logic [31:0] rd_addr, wr_addr, wr_data, wr_mask;
    logic [31:0] core_read_data;
    logic        core_done, stall, fault;
    logic        bus_valid, bus_write;
    logic [31:0] bus_address, bus_write_data, bus_write_mask;
    logic        bus_ready, bus_error;
    logic [31:0] bus_read_data;

    // Second instance, timeout disabled.
    logic        b_reset, b_rd_req, b_ready;
    logic [31:0] b_read_data;
    logic        b_done, b_stall, b_fault, b_valid, b_write;
    logic [31:0] b_addr, b_wdata, b_wmask;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } xact_t;

    xact_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    core_bus_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .core_read_request(rd_req), .core_read_address(rd_addr),
        .core_write_request(wr_req), .core_write_address(wr_addr),
        .core_write_data(wr_data), .core_write_mask(wr_mask),
        .core_read_data(core_read_data), .core_done(core_done),
        .stall(stall), .fault(fault),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_address(bus_address),
        .bus_write_data(bus_write_data), .bus_write_mask(bus_write_mask),
        .bus_ready(bus_ready), .bus_read_data(bus_read_data), .bus_error(bus_error)
    );

    core_bus_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_noto (
        .clk(clk), .reset(b_reset),
        .core_read_request(b_rd_req), .core_read_address(32'h0000_0200),
        .core_write_request(1'b0), .core_write_address(32'h0),
        .core_write_data(32'h0), .core_write_mask(32'h0),
        .core_read_data(b_read_data), .core_done(b_done),
        .stall(b_stall), .fault(b_fault),
        .bus_valid(b_valid), .bus_write(b_write), .bus_address(b_addr),
        .bus_write_data(b_wdata), .bus_write_mask(b_wmask),
        .bus_ready(b_ready), .bus_read_data(32'hCAFE_F00D), .bus_error(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // One core request (load, store or both) served by the slave model with
    // ww wait cycles on the store phase and wr_w on the load phase.
    task automatic run_xfer(input bit rd, input bit wr,
                            input logic [31:0] ra, input logic [31:0] wa,
                            input logic [31:0] wd, input logic [31:0] wm,
                            input int ww, input int wr_w);
        int    exp_lat;
        int    c;
        int    waited;
        int    phase_wait;
        bit    done;
        xact_t x;
        exp_q.delete();
        if (wr) begin
            x.wr = 1'b1; x.addr = wa; x.data = wd; x.mask = wm;
            exp_q.push_back(x);
        end
        if (rd) begin
            x.wr = 1'b0; x.addr = ra; x.data = '0; x.mask = '0;
            exp_q.push_back(x);
        end
        exp_lat = (rd && wr) ? 3 + ww + wr_w : 2 + (wr ? ww : wr_w);
        rd_req = rd; wr_req = wr;
        rd_addr = ra; wr_addr = wa; wr_data = wd; wr_mask = wm;
        bus_ready = 1'b0; bus_error = 1'b0;
        c = 0; waited = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            c++;
            if (core_done) begin
                chk("latency", c, exp_lat);
                chk("rdata", core_read_data, last_rdata);
                chk("done_stall", stall, 0);
                chk("done_valid", bus_valid, 0);
                chk("queue_empty", exp_q.size(), 0);
                done = 1;
                rd_req = 1'b0; wr_req = 1'b0; bus_ready = 1'b0;
            end else begin
                chk("busy_stall", stall, 1);
                chk("busy_valid", bus_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    x = exp_q[0];
                    chk("bus_write", bus_write, x.wr);
                    chk("bus_addr", bus_address, x.addr);
                    if (x.wr) begin
                        chk("bus_wdata", bus_write_data, x.data);
                        chk("bus_wmask", bus_write_mask, x.mask);
                    end
                    phase_wait = x.wr ? ww : wr_w;
                    if (waited == phase_wait) begin
                        bus_ready = 1'b1;
                        if (x.wr) begin
                            bus_read_data = $urandom;
                            mem[x.addr] = (mem_rd(x.addr) & ~x.mask) | (x.data & x.mask);
                        end else begin
                            bus_read_data = mem_rd(x.addr);
                            last_rdata = bus_read_data;
                        end
                        void'(exp_q.pop_front());
                        waited = 0;
                    end else begin
                        bus_ready = 1'b0;
                        bus_read_data = $urandom;
                        waited++;
                    end
                end
            end
        end
        chk("done_seen", done, 1);
        step();
        chk("done_pulse", core_done, 0);
        chk("rdata_hold", core_read_data, last_rdata);
        $display("xfer rd=%0d wr=%0d ra=%h wa=%h waits=%0d/%0d latency=%0d", rd, wr, ra, wa, ww, wr_w, c);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        last_rdata = '0;
    endtask

    initial begin
        reset = 1'b1; rd_req = 0; wr_req = 0;
        rd_addr = 0; wr_addr = 0; wr_data = 0; wr_mask = 0;
        bus_ready = 0; bus_error = 0; bus_read_data = 0;
        b_reset = 1'b1; b_rd_req = 0; b_ready = 0;
        last_rdata = '0;
        step();
        step();
        chk("rst_valid", bus_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fault", fault, 0);
        chk("rst_done", core_done, 0);
        chk("rst_rdata", core_read_data, 0);
        chk("rst_addr", bus_address, 0);
        reset = 1'b0;
        step();

        // Zero-wait load.
        mem[32'h100] = 32'hDEAD_BEEF;
        run_xfer(1, 0, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("load_beef", core_read_data, 32'hDEAD_BEEF);
        // Store with three wait cycles.
        run_xfer(0, 1, 32'h0, 32'h40, 32'h1234_5678, 32'h0000_FFFF, 3, 0);
        // Simultaneous store and load, zero wait.
        run_xfer(1, 1, 32'h84, 32'h80, 32'hAAAA_5555, 32'hFFFF_FFFF, 0, 0);
        // Store then load of the same word: load must see the stored value.
        run_xfer(1, 1, 32'h40, 32'h40, 32'hFFFF_0000, 32'hFF00_FF00, 1, 2);

        // Randomised mix of loads, stores and combined requests.
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] ra, wa;
            kind = $urandom_range(0, 2);
            ra = 32'h300 + 32'($urandom_range(0, 7)) * 4;
            wa = 32'h300 + 32'($urandom_range(0, 7)) * 4;
            run_xfer(kind != 1, kind != 0, ra, wa, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Timeout: dead slave, TIMEOUT_CYCLES=4.
        rd_req = 1'b1; rd_addr = 32'h500; bus_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("to_valid", bus_valid, 1);
            chk("to_nofault", fault, 0);
        end
        step();
        chk("to_valid_drop", bus_valid, 0);
        chk("to_fault", fault, 1);
        chk("to_stall", stall, 1);
        chk("to_nodone", core_done, 0);
        $display("timeout fault=%0d valid=%0d", fault, bus_valid);
        rd_req = 1'b0;
        do_reset();
        chk("to_rst_fault", fault, 0);

        // Bus error on a load handshake.
        rd_req = 1'b1; rd_addr = 32'h600;
        step();
        chk("err_valid", bus_valid, 1);
        bus_ready = 1'b1; bus_error = 1'b1; bus_read_data = 32'h1111_2222;
        step();
        bus_ready = 1'b0; bus_error = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("err_fault", fault, 1);
            chk("err_valid0", bus_valid, 0);
            chk("err_nodone", core_done, 0);
            chk("err_stall", stall, 1);
            step();
        end
        chk("err_rdata", core_read_data, 0);
        $display("bus error fault=%0d", fault);
        rd_req = 1'b0;
        do_reset();
        chk("err_rst_fault", fault, 0);
        chk("err_rst_stall", stall, 0);

        // Reset while a store is waiting.
        wr_req = 1'b1; wr_addr = 32'h700; wr_data = 32'h5; wr_mask = 32'hF;
        bus_ready = 1'b0;
        step();
        step();
        chk("mid_valid_pre", bus_valid, 1);
        reset = 1'b1;
        step();
        chk("mid_valid", bus_valid, 0);
        chk("mid_stall", stall, 0);
        chk("mid_fault", fault, 0);
        chk("mid_done", core_done, 0);
        reset = 1'b0; wr_req = 1'b0; last_rdata = '0;
        step();
        $display("reset mid-transfer valid=%0d", bus_valid);
        run_xfer(1, 0, 32'h100, 32'h0, 32'h0, 32'h0, 1, 1);

        // Timeout disabled: 1000 idle-slave cycles leave the load waiting.
        b_reset = 1'b0; b_rd_req = 1'b1; b_ready = 1'b0;
        for (int c = 0; c < 1000; c++) step();
        chk("noto_valid", b_valid, 1);
        chk("noto_fault", b_fault, 0);
        chk("noto_stall", b_stall, 1);
        chk("noto_addr", b_addr, 32'h200);
        chk("noto_done", b_done, 0);
        $display("no-timeout valid=%0d fault=%0d", b_valid, b_fault);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
